truth_table_scanner: RTL and testbench

Sequential exhaustive-sweep reader for 4-input combinational logic functions. On start it drives all 16 input combinations (w,x,y,z) onto an external combinational block and waits a settle interval. It then samples the 1-bit result and assembles a 16-bit truth table. It compares each sample against a latched expected minterm mask and reports a mismatch count, the first failing index, and a pass flag.

---
 rtl/tt_pkg.sv | 24 ++
 rtl/tt_settle_timer.sv | 26 ++
 rtl/truth_table_scanner.sv | 130 +++++++++++++
 tb/tb_truth_table_scanner.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table scanner.
package tt_pkg;

  localparam int TABLE_W = 16;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_e;

  function automatic logic [CNT_W-1:0] popcount16(input logic [TABLE_W-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < TABLE_W; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter; o_expire flags the last cycle of the settle window.
module tt_settle_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_expire
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_expire = (r_count == W'(1));

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps all 16 inputs of a 4-input function, captures its truth table and
// compares it against a mask latched at start.
module truth_table_scanner
  import tt_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [TABLE_W-1:0]  i_expected,
  input  logic                i_dut_out,
  output logic [IDX_W-1:0]    o_dut_in,
  output logic                o_busy,
  output logic                o_done,
  output logic [TABLE_W-1:0]  o_table_out,
  output logic [CNT_W-1:0]    o_mismatch_cnt,
  output logic                o_fail_valid,
  output logic [IDX_W-1:0]    o_first_fail_idx,
  output logic                o_pass
);

  localparam logic [IDX_W-1:0] SETTLE_V = IDX_W'(SETTLE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TABLE_W - 1);

  state_e               r_state;
  state_e               w_next;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     r_dut_in;
  logic [TABLE_W-1:0]   r_exp;
  logic [TABLE_W-1:0]   r_table;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_fail_valid;
  logic [IDX_W-1:0]     r_first_fail;
  logic                 r_pass;
  logic                 w_load;
  logic                 w_expire;
  logic                 w_busy;
  logic                 w_done;

  // The timer is reloaded whenever a new input value is driven.
  assign w_load = ((r_state == IDLE) && i_start) ||
                  ((r_state == SAMPLE) && (r_idx != LAST_IDX));

  tt_settle_timer #(.W(IDX_W)) u_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (w_load),
    .i_value  (SETTLE_V),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b1;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (i_start) w_next = WAIT;
      end
      WAIT:   if (w_expire) w_next = SAMPLE;
      SAMPLE: w_next = (r_idx == LAST_IDX) ? FINISH : WAIT;
      FINISH: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_idx        <= '0;
      r_dut_in     <= '0;
      r_exp        <= '0;
      r_table      <= '0;
      r_cnt        <= '0;
      r_fail_valid <= 1'b0;
      r_first_fail <= '0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_exp        <= i_expected;
            r_table      <= '0;
            r_cnt        <= '0;
            r_fail_valid <= 1'b0;
            r_first_fail <= '0;
            r_pass       <= 1'b0;
            r_idx        <= '0;
            r_dut_in     <= '0;
          end
        end
        SAMPLE: begin
          r_table[r_idx] <= i_dut_out;
          if (i_dut_out != r_exp[r_idx]) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (!r_fail_valid) begin
              r_fail_valid <= 1'b1;
              r_first_fail <= r_idx;
            end
          end
          if (r_idx != LAST_IDX) begin
            r_idx    <= r_idx + IDX_W'(1);
            r_dut_in <= r_idx + IDX_W'(1);
          end
        end
        FINISH: r_pass <= (r_cnt == '0);
        default: ;
      endcase
    end
  end

  assign o_dut_in         = r_dut_in;
  assign o_busy           = w_busy;
  assign o_done           = w_done;
  assign o_table_out      = r_table;
  assign o_mismatch_cnt   = r_cnt;
  assign o_fail_valid     = r_fail_valid;
  assign o_first_fail_idx = r_first_fail;
  assign o_pass           = r_pass;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench: SETTLE=1 instance (a) with a zero-delay function and
// SETTLE=3 instance (b) with a two-cycle delayed function.
module tb_truth_table_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [15:0] tbl;
    int          cnt;
    logic        fv;
    int          ffi;
    logic        pass;
    int          done_cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  logic        a_reset, a_start, a_dout;
  logic [15:0] a_exp, func_a;
  logic [3:0]  a_din, a_ffi;
  logic        a_busy, a_done, a_fv, a_pass;
  logic [15:0] a_tbl;
  logic [4:0]  a_cnt;

  logic        b_reset, b_start, b_dout;
  logic [15:0] b_exp, func_b;
  logic [3:0]  b_din, b_ffi, b_d1, b_d2;
  logic        b_busy, b_done, b_fv, b_pass;
  logic [15:0] b_tbl;
  logic [4:0]  b_cnt;

  assign a_dout = func_a[a_din];
  always @(posedge clk) begin
    b_d1 <= b_din;
    b_d2 <= b_d1;
  end
  assign b_dout = func_b[b_d2];

  truth_table_scanner #(.SETTLE(1)) dut_a (
    .i_clk(clk), .i_reset(a_reset), .i_start(a_start), .i_expected(a_exp),
    .i_dut_out(a_dout), .o_dut_in(a_din), .o_busy(a_busy), .o_done(a_done),
    .o_table_out(a_tbl), .o_mismatch_cnt(a_cnt), .o_fail_valid(a_fv),
    .o_first_fail_idx(a_ffi), .o_pass(a_pass)
  );

  truth_table_scanner #(.SETTLE(3)) dut_b (
    .i_clk(clk), .i_reset(b_reset), .i_start(b_start), .i_expected(b_exp),
    .i_dut_out(b_dout), .o_dut_in(b_din), .o_busy(b_busy), .o_done(b_done),
    .o_table_out(b_tbl), .o_mismatch_cnt(b_cnt), .o_fail_valid(b_fv),
    .o_first_fail_idx(b_ffi), .o_pass(b_pass)
  );

  function automatic logic f_formula(input int i);
    logic w, x, y, z;
    w = i[3]; x = i[2]; y = i[1]; z = i[0];
    return (!w && !x && y && !z) || (w && x && z) || (w && !y && z);
  endfunction

  function automatic logic [15:0] formula_table();
    logic [15:0] t;
    for (int i = 0; i < 16; i++) t[i] = f_formula(i);
    return t;
  endfunction

  // Exhaustive sweep reads back the function itself; compare against mask.
  function automatic exp_t model(input logic [15:0] func, input logic [15:0] expv,
                                 input int done_cyc);
    exp_t e;
    e.tbl = func; e.cnt = 0; e.fv = 1'b0; e.ffi = 0; e.done_cyc = done_cyc;
    for (int i = 0; i < 16; i++) begin
      if (func[i] != expv[i]) begin
        e.cnt++;
        if (!e.fv) begin
          e.fv  = 1'b1;
          e.ffi = i;
        end
      end
    end
    e.pass = (e.cnt == 0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_zero_a();
    chk("a_rst_busy", 32'(a_busy), 0);
    chk("a_rst_done", 32'(a_done), 0);
    chk("a_rst_din", 32'(a_din), 0);
    chk("a_rst_tbl", 32'(a_tbl), 0);
    chk("a_rst_cnt", 32'(a_cnt), 0);
    chk("a_rst_fv", 32'(a_fv), 0);
    chk("a_rst_ffi", 32'(a_ffi), 0);
    chk("a_rst_pass", 32'(a_pass), 0);
  endtask

  task automatic start_a(input logic [15:0] expv);
    @(negedge clk);
    a_start = 1'b1;
    a_exp   = expv;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    qa.push_back(model(func_a, expv, cyc + 32));
    chk("a_busy_after_start", 32'(a_busy), 1);
  endtask

  task automatic start_b(input logic [15:0] expv);
    @(negedge clk);
    b_start = 1'b1;
    b_exp   = expv;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    qb.push_back(model(func_b, expv, cyc + 64));
    chk("b_busy_after_start", 32'(b_busy), 1);
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (a_busy && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) chk("a_idle_timeout", 32'(a_busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle_b();
    int n = 0;
    while (b_busy && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) chk("b_idle_timeout", 32'(b_busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_din_a(input logic [3:0] v);
    int n = 0;
    while (a_din != v && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("a_din_timeout", 32'(a_din), 32'(v));
  endtask

  // Monitor for instance a: checks results on done, pass one cycle later.
  logic [3:0] log_a[$];
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(posedge clk); #1;
      if (!a_busy) log_a.delete();
      else if (!a_done) log_a.push_back(a_din);
      if (a_done) begin
        if (qa.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected_done actual=1 required=0");
        end else begin
          e = qa.pop_front();
          chk("a_table", 32'(a_tbl), 32'(e.tbl));
          chk("a_mismatch_cnt", 32'(a_cnt), 32'(e.cnt));
          chk("a_fail_valid", 32'(a_fv), 32'(e.fv));
          if (e.fv) chk("a_first_fail_idx", 32'(a_ffi), 32'(e.ffi));
          chk("a_done_cycle", 32'(cyc), 32'(e.done_cyc));
          chk("a_din_final", 32'(a_din), 15);
          ok = (log_a.size() == 32);
          for (int j = 0; j < log_a.size(); j++) if (log_a[j] != 4'(j / 2)) ok = 1'b0;
          chk("a_din_sequence", 32'(ok), 1);
          @(posedge clk); #1;
          chk("a_pass", 32'(a_pass), 32'(e.pass));
          chk("a_done_single", 32'(a_done), 0);
          chk("a_busy_end", 32'(a_busy), 0);
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (b_done) begin
        if (qb.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected_done actual=1 required=0");
        end else begin
          e = qb.pop_front();
          chk("b_table", 32'(b_tbl), 32'(e.tbl));
          chk("b_mismatch_cnt", 32'(b_cnt), 32'(e.cnt));
          chk("b_fail_valid", 32'(b_fv), 32'(e.fv));
          if (e.fv) chk("b_first_fail_idx", 32'(b_ffi), 32'(e.ffi));
          chk("b_done_cycle", 32'(cyc), 32'(e.done_cyc));
          @(posedge clk); #1;
          chk("b_pass", 32'(b_pass), 32'(e.pass));
          chk("b_busy_end", 32'(b_busy), 0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] r;
    func_a = formula_table();
    func_b = formula_table();
    a_reset = 1'b1; a_start = 1'b0; a_exp = '0;
    b_reset = 1'b1; b_start = 1'b0; b_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_a();
    chk("b_rst_busy", 32'(b_busy), 0);
    a_reset = 1'b0;
    b_reset = 1'b0;

    start_a(16'hA204); wait_idle_a();
    start_a(16'hA205); wait_idle_a();
    start_a(16'h5DFB); wait_idle_a();

    // Start and expected-mask changes mid-scan must be ignored.
    start_a(16'hA204);
    wait_din_a(4'd7);
    @(negedge clk); a_start = 1'b1; a_exp = 16'h0000;
    @(negedge clk); a_start = 1'b0; a_exp = 16'hFFFF;
    wait_idle_a();

    // Reset mid-scan aborts with no done pulse.
    start_a(16'hA204);
    wait_din_a(4'd7);
    @(negedge clk); qa.delete(); a_reset = 1'b1;
    @(posedge clk); #1;
    check_zero_a();
    a_reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("a_idle_after_abort", 32'(a_busy), 0);
    start_a(16'hA205); wait_idle_a();

    for (int n = 0; n < 8; n++) begin
      func_a = 16'($urandom);
      r = 16'($urandom);
      case (n % 3)
        0: a_exp = func_a;
        1: a_exp = func_a ^ (16'h1 << $urandom_range(15, 0));
        default: a_exp = r;
      endcase
      start_a(a_exp); wait_idle_a();
    end

    start_b(16'hA204); wait_idle_b();
    start_b(16'h5DFB); wait_idle_b();
    for (int n = 0; n < 3; n++) begin
      func_b = 16'($urandom);
      start_b(16'($urandom)); wait_idle_b();
    end

    repeat (3) @(posedge clk);
    chk("a_queue_drained", 32'(qa.size()), 0);
    chk("b_queue_drained", 32'(qb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
